// File: rtl/rgb_stream_packer.sv
// RGB video to AXI-stream packer: frames on vs, tags sof/eol, buffers
// pixels in a small FIFO and measures line width and lines per frame.
module rgb_stream_packer #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic              pclk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] rgb_i,
  input  logic              de_i,
  input  logic              vs_i,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tuser_o,
  output logic              m_tlast_o,
  output logic              overflow_o,
  output logic [15:0]       frame_cnt_o,
  output logic [CNT_W-1:0]  line_width_o,
  output logic [CNT_W-1:0]  frame_lines_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    WAIT_VS, ARMED, ACTIVE, DROP
  } state_t;

  state_t            state;
  logic              vs_q;
  logic              de_q;
  logic              stg_v;
  logic              stg_sof;
  logic [DATA_W-1:0] stg_data;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       mem_cnt;
  logic [AW+1:0]     occ;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  lines;

  logic vs_rise;
  logic in_frame;
  logic pop;
  logic load;
  logic full;
  logic push_req;
  logic push_eol;
  logic push_ok;
  logic ovf;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign vs_rise  = vs_i & ~vs_q;
  assign in_frame = (state == ARMED) | (state == ACTIVE);

  // Output register is the FIFO head, so it counts toward occupancy.
  assign occ  = {1'b0, mem_cnt} + {{(AW+1){1'b0}}, m_tvalid_o};
  assign full = (occ == (AW+2)'(FIFO_DEPTH));
  assign pop  = m_tvalid_o & m_tready_i;
  assign load = (~m_tvalid_o | m_tready_i) & (mem_cnt != '0);

  always_comb begin
    push_req = 1'b0;
    push_eol = 1'b0;
    if (state == ACTIVE && stg_v) begin
      push_req = 1'b1;
      push_eol = vs_rise | ~de_i;
    end
  end

  assign push_ok = push_req & (~full | pop);
  assign ovf     = push_req & full & ~pop;

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= WAIT_VS;
      vs_q        <= 1'b0;
      stg_v       <= 1'b0;
      stg_sof     <= 1'b0;
      stg_data    <= '0;
      overflow_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      vs_q <= vs_i;
      if (ovf) overflow_o <= 1'b1;
      unique case (state)
        WAIT_VS: begin
          if (vs_rise) state <= ARMED;
        end
        ARMED: begin
          if (!vs_rise && de_i) begin
            stg_v    <= 1'b1;
            stg_sof  <= 1'b1;
            stg_data <= rgb_i;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            stg_v       <= 1'b0;
            state       <= ARMED;
            frame_cnt_o <= frame_cnt_o + 16'd1;
          end else if (ovf) begin
            stg_v <= 1'b0;
            state <= DROP;
          end else if (de_i) begin
            stg_v    <= 1'b1;
            stg_sof  <= 1'b0;
            stg_data <= rgb_i;
          end else begin
            stg_v <= 1'b0;
          end
        end
        DROP: begin
          if (vs_rise) begin
            state       <= ARMED;
            frame_cnt_o <= frame_cnt_o + 16'd1;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge pclk_i) begin
    if (push_ok) mem[wr_ptr] <= {stg_sof, push_eol, stg_data};
  end

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      m_tvalid_o <= 1'b0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load)    rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, load})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (load) begin
        {m_tuser_o, m_tlast_o, m_tdata_o} <= mem[rd_ptr];
        m_tvalid_o <= 1'b1;
      end else if (pop) begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_q          <= 1'b0;
      run_cnt       <= '0;
      lines         <= '0;
      line_width_o  <= '0;
      frame_lines_o <= '0;
    end else begin
      de_q    <= de_i;
      run_cnt <= de_i ? sat_inc(run_cnt) : '0;
      if (!de_i && de_q && in_frame) line_width_o <= run_cnt;
      if (vs_rise) lines <= '0;
      else if (de_i && !de_q && in_frame) lines <= sat_inc(lines);
      if (vs_rise && state == ACTIVE) frame_lines_o <= lines;
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Scoreboard bench for rgb_stream_packer: expected beats are queued as
// pixels are driven and matched against the stream as it drains.
module tb_rgb_stream_packer;

  logic        pclk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [23:0] rgb_i = '0;
  logic        de_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [23:0] m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i = 1'b0;
  logic        m_tuser_o;
  logic        m_tlast_o;
  logic        overflow_o;
  logic [15:0] frame_cnt_o;
  logic [11:0] line_width_o;
  logic [11:0] frame_lines_o;

  rgb_stream_packer dut (
    .pclk_i        (pclk_i),
    .rstn_i        (rstn_i),
    .rgb_i         (rgb_i),
    .de_i          (de_i),
    .vs_i          (vs_i),
    .m_tdata_o     (m_tdata_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
    .m_tuser_o     (m_tuser_o),
    .m_tlast_o     (m_tlast_o),
    .overflow_o    (overflow_o),
    .frame_cnt_o   (frame_cnt_o),
    .line_width_o  (line_width_o),
    .frame_lines_o (frame_lines_o)
  );

  always #5 pclk_i = ~pclk_i;

  logic [25:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int cyc = 0;
  int first_v = -1;
  int de_cyc = 0;
  int b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge pclk_i) cyc++;

  // Beats transfer on the next rising edge when valid&ready here.
  always @(negedge pclk_i) begin
    if (rstn_i) begin
      if (m_tvalid_o && first_v < 0) first_v = cyc;
      if (m_tvalid_o && m_tready_i) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          check("beat", {m_tuser_o, m_tlast_o, m_tdata_o},
                exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic idle(input int n);
    de_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vs_pulse();
    de_i = 1'b0;
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    tick();
  endtask

  task automatic line(input int n, input logic [23:0] base,
                      input bit sof1, input int keep, input int rdy_from);
    for (int k = 1; k <= n; k++) begin
      if (rdy_from > 0) m_tready_i = (k >= rdy_from);
      rgb_i = base + 24'(k);
      de_i  = 1'b1;
      if (k <= keep)
        exp_q.push_back({sof1 && k == 1, k == n, rgb_i});
      tick();
    end
  endtask

  initial begin
    repeat (3) @(posedge pclk_i);
    #2 rstn_i = 1'b1;
    tick();
    check("rst_tvalid", 64'(m_tvalid_o), 64'd0);
    check("rst_head", {m_tuser_o, m_tlast_o, m_tdata_o}, 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_fcnt", 64'(frame_cnt_o), 64'd0);
    check("rst_meas", {line_width_o, frame_lines_o}, 64'd0);

    m_tready_i = 1'b1;
    line(6, 24'h0AA000, 1'b0, 0, 0);
    idle(6);
    check("pre_vs_beats", 64'(beats), 64'd0);
    check("pre_vs_valid", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pre_vs_width", 64'(line_width_o), 64'd0);

    vs_pulse();
    check("arm_fcnt", 64'(frame_cnt_o), 64'd0);
    first_v = -1;
    de_cyc = cyc + 1;
    for (int l = 0; l < 3; l++) begin
      line(4, 24'(4 * l), l == 0, 4, 0);
      idle(2);
    end
    idle(8);
    check("latency", 64'(first_v - de_cyc), 64'd2);
    vs_i = 1'b1;
    tick();
    check("f1_width", 64'(line_width_o), 64'd4);
    check("f1_lines", 64'(frame_lines_o), 64'd3);
    check("f1_fcnt", 64'(frame_cnt_o), 64'd1);
    vs_i = 1'b0;
    tick();
    check("f1_beats", 64'(beats), 64'd12);

    b0 = beats;
    m_tready_i = 1'b0;
    line(24, 24'h000700, 1'b1, 24, 18);
    m_tready_i = 1'b1;
    idle(30);
    check("fullpp_ovf", 64'(overflow_o), 64'd0);
    check("fullpp_beats", 64'(beats - b0), 64'd24);
    check("fullpp_sb", 64'(exp_q.size()), 64'd0);

    b0 = beats;
    m_tready_i = 1'b0;
    line(20, 24'h000100, 1'b0, 16, 0);
    idle(3);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_valid", 64'(m_tvalid_o), 64'd1);
    check("ovf_head", {m_tuser_o, m_tlast_o, m_tdata_o}, 64'h000101);
    idle(4);
    check("hold_head", 64'(m_tdata_o), 64'h000101);
    m_tready_i = 1'b1;
    idle(25);
    check("ovf_drain", 64'(beats - b0), 64'd16);
    check("ovf_width", 64'(line_width_o), 64'd24);
    vs_pulse();
    check("f2_fcnt", 64'(frame_cnt_o), 64'd2);
    check("f2_lines", 64'(frame_lines_o), 64'd3);
    check("ovf_sticky", 64'(overflow_o), 64'd1);

    line(3, 24'h000200, 1'b1, 3, 0);
    idle(2);
    line(5, 24'h000300, 1'b0, 5, 0);
    de_i = 1'b0;
    vs_i = 1'b1;
    tick();
    check("vsde_width", 64'(line_width_o), 64'd5);
    check("vsde_lines", 64'(frame_lines_o), 64'd2);
    check("vsde_fcnt", 64'(frame_cnt_o), 64'd3);
    vs_i = 1'b0;
    tick();
    line(2, 24'h000400, 1'b1, 2, 0);
    idle(10);
    check("vsde_sb", 64'(exp_q.size()), 64'd0);

    m_tready_i = 1'b0;
    line(9, 24'h000600, 1'b0, 0, 0);
    check("pre_rst_valid", 64'(m_tvalid_o), 64'd1);
    #3 rstn_i = 1'b0;
    #1;
    check("arst_valid", 64'(m_tvalid_o), 64'd0);
    check("arst_head", {m_tuser_o, m_tlast_o, m_tdata_o}, 64'd0);
    check("arst_ovf", 64'(overflow_o), 64'd0);
    check("arst_cnts", {frame_cnt_o, line_width_o, frame_lines_o}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge pclk_i);
    #2 rstn_i = 1'b1;
    b0 = beats;
    m_tready_i = 1'b1;
    line(6, 24'h000800, 1'b0, 0, 0);
    idle(8);
    check("post_rst_beats", 64'(beats - b0), 64'd0);
    vs_pulse();
    line(2, 24'h000500, 1'b1, 2, 0);
    idle(8);
    check("post_rst_out", 64'(beats - b0), 64'd2);
    check("post_rst_fcnt", 64'(frame_cnt_o), 64'd0);
    check("final_sb", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_stream_packer.md
RGB_STREAM_PACKER -- requirements
Module: rgb_stream_packer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, meaning pixel width carried on rgb_i/m_tdata_o.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning entry count (power of two, 4..256).
REQ-003 The block SHALL have parameter CNT_W, default 12, meaning width of pixel/line measurement counters.
REQ-004 The block SHALL have port pclk_i, input, 1, the single pixel clock; all logic on its rising edge.
REQ-005 The block SHALL have port rstn_i, input, 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port rgb_i, input, DATA_W, pixel data, valid when de_i=1.
REQ-007 The block SHALL have port de_i, input, 1, pixel data enable, one pixel per cycle when high.
REQ-008 The block SHALL have port vs_i, input, 1, vertical sync, active high; rising edge marks a new frame.
REQ-009 The block SHALL have ports m_tdata_o (output, DATA_W), m_tvalid_o (output, 1), m_tready_i (input, 1), m_tuser_o (output, 1, start of frame), m_tlast_o (output, 1, end of line).
REQ-010 The block SHALL have ports overflow_o (output, 1, sticky), frame_cnt_o (output, 16), line_width_o (output, CNT_W), frame_lines_o (output, CNT_W).

Function
REQ-011 States SHALL be WAIT_VS, ARMED, ACTIVE and DROP; reset enters WAIT_VS.
REQ-012 WAIT_VS->ARMED SHALL occur on a vs_i rising edge (vs_i=1 while previous-cycle vs_i=0); de_i is ignored in WAIT_VS.
REQ-013 In ARMED, the first de_i=1 pixel SHALL be tagged sof=1; state then goes to ACTIVE. Later pixels SHALL be tagged sof=0.
REQ-014 A vs_i rising edge in ACTIVE or DROP SHALL enter ARMED and increment frame_cnt_o (mod 2^16); a rising edge in ARMED SHALL NOT increment it.
REQ-015 Accepted pixels SHALL first enter a one-entry stage register. A staged pixel SHALL be pushed to the FIFO when the next de_i=1 pixel arrives (eol=0). It SHALL also be pushed when de_i=0 in that cycle (eol=1).
REQ-016 If a vs_i rising edge coincides with a staged pixel, that pixel SHALL be pushed with eol=1 in the same cycle, before re-arming.
REQ-017 FIFO entries SHALL be {sof, eol, data}; m_tuser_o/m_tlast_o/m_tdata_o SHALL present the head entry while m_tvalid_o=1.
REQ-018 A pop SHALL occur iff m_tvalid_o=1 and m_tready_i=1. Head outputs SHALL stay stable while m_tvalid_o=1 and m_tready_i=0.
REQ-019 Latency SHALL be: a pixel sampled at edge N appears at m_tvalid_o=1 no earlier than after edge N+2 (push at N+1, output valid after N+2) when the FIFO is empty.
REQ-020 A push while full SHALL be accepted if a pop occurs in the same cycle. Otherwise the pixel SHALL be discarded, overflow_o set to 1 (sticky until reset), and the state SHALL enter DROP.
REQ-021 In DROP, no pixels SHALL be staged or pushed. Already-queued entries SHALL continue draining.
REQ-022 line_width_o SHALL update to the pixel count of each de_i high run on its falling edge in ARMED/ACTIVE.
REQ-023 frame_lines_o SHALL update to the number of de_i runs in the completed frame on each vs_i rising edge that leaves ACTIVE.
REQ-024 Counters SHALL saturate at 2^CNT_W-1.

Reset
REQ-025 Assertion of rstn_i SHALL asynchronously clear: state=WAIT_VS, FIFO empty, stage empty, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, overflow_o=0, frame_cnt_o=0, line_width_o=0, frame_lines_o=0.
REQ-026 Reset mid-frame SHALL discard all queued pixels. After release, output SHALL resume only after a new vs_i rising edge.

Verification
REQ-027 Scenario: reset release; pixels before any vs_i edge -> m_tvalid_o stays 0.
REQ-028 Scenario: vs pulse, then 3 lines of 4 pixels (0x000001..0x00000C), m_tready_i=1 -> 12 beats in order, tuser only on 0x000001, tlast on 0x4/0x8/0xC, first tvalid 2 cycles after first de. On the next vs edge: line_width_o=4, frame_lines_o=3, frame_cnt_o=1.
REQ-029 Scenario: m_tready_i=0, FIFO_DEPTH=16, 20-pixel line -> 16 entries held, overflow_o=1, remaining pixels dropped. Raising tready drains exactly 16 beats; the next frame is packed normally.
REQ-030 Scenario: vs_i rises in the same cycle de_i falls after a 5-pixel line -> pixel 5 carries tlast=1 and the next frame's first pixel carries tuser=1.
REQ-031 Scenario: FIFO full with simultaneous push and pop -> no overflow, count unchanged, data order preserved.
REQ-032 Scenario: rstn_i asserted asynchronously mid-line with 8 queued entries -> outputs zero immediately without a clock edge, and nothing is emitted until a new vs edge.
